// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and sequencer in front of a
// single-port memory (valid/ready handshake, wr_rd select).
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   When defined, a watchdog abandons a memory request that has stalled for
//   TIMEOUT_CYCLES cycles. It then raises the sticky err output and still
//   completes the requester with a ready pulse. When undefined, the err port
//   does not exist and ISSUE waits for m_ready indefinitely.
//
// Handshakes:
//   Requester side: rN_valid is held, with stable fields, until rN_ready
//   pulses for one cycle. Requester inputs are sampled only in IDLE.
//   Memory side: m_valid and m_* stay stable until the cycle in which
//   m_ready is 1. That cycle is the handshake, and m_rdata is captured on it.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   rN_valid/wr_rd/addr/wdata   requester N command (N = 0, 1)
//   rN_ready, rN_rdata          one-cycle completion pulse, held read data
//   m_valid/wr_rd/addr/wdata    memory command
//   m_ready, m_rdata            memory accept and read data
//   grant                       one-hot owner of the current transaction
//   err                         sticky timeout flag (MEM_ARB_TIMEOUT_EN only)

module mem_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_valid,
    input  logic                  r0_wr_rd,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ready,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_valid,
    input  logic                  r1_wr_rd,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ready,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  m_valid,
    output logic                  m_wr_rd,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic [1:0]            grant
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                  err
`endif
);

    // Parameter sanity check (elaboration time only).
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last;     // previous winner: 0 = r0, 1 = r1
    logic                  r_owner;    // winner of the current transaction
    logic [1:0]            r_grant;
    logic                  r_m_valid;
    logic                  r_m_wr_rd;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [DATA_WIDTH-1:0] r_m_wdata;
    logic [1:0]            r_ready;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;
`endif

    // On a tie the requester that did not win last time goes next. A lone
    // requester wins outright, which is simply r1_valid here.
    logic w_pick;
    assign w_pick = (r0_valid && r1_valid) ? ~r_last : r1_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_grant   <= 2'b00;
            r_m_valid <= 1'b0;
            r_m_wr_rd <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_ready   <= 2'b00;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            // Completion pulses last exactly one cycle.
            r_ready <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (r0_valid || r1_valid) begin
                        r_owner   <= w_pick;
                        r_last    <= w_pick;
                        r_grant   <= w_pick ? 2'b10 : 2'b01;
                        r_m_valid <= 1'b1;
                        r_m_wr_rd <= w_pick ? r1_wr_rd : r0_wr_rd;
                        r_m_addr  <= w_pick ? r1_addr  : r0_addr;
                        r_m_wdata <= w_pick ? r1_wdata : r0_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        // Writes leave the requester's read data untouched.
                        if (!r_m_wr_rd) begin
                            if (r_owner) r_rdata1 <= m_rdata;
                            else         r_rdata0 <= m_rdata;
                        end
                        r_ready[r_owner] <= 1'b1;
                        r_state          <= S_RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // This stall cycle would bring the count to TIMEOUT_CYCLES:
                    // give up, flag it and release the requester.
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_m_valid        <= 1'b0;
                        r_err            <= 1'b1;
                        r_ready[r_owner] <= 1'b1;
                        r_state          <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    r_grant <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign m_valid  = r_m_valid;
    assign m_wr_rd  = r_m_wr_rd;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign r0_ready = r_ready[0];
    assign r1_ready = r_ready[1];
    assign r0_rdata = r_rdata0;
    assign r1_rdata = r_rdata1;
`ifdef MEM_ARB_TIMEOUT_EN
    assign err      = r_err;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. The requesters are modelled as queues of pending
// commands: a requester is valid while its queue is non-empty and retires the
// head when it sees its ready pulse. The memory is an array with random or
// scripted m_ready. The reference model works at transaction level. It picks
// a winner by the round-robin rule, keeps the memory contents and the
// per-requester read data, and predicts every observable output each cycle.
// Build with +define+MEM_ARB_TIMEOUT_EN to also exercise the watchdog.

module tb_mem_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r0_wr_rd, r0_ready;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_valid, r1_wr_rd, r1_ready;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          m_valid, m_wr_rd, m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [1:0]    grant;
`ifdef MEM_ARB_TIMEOUT_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .r0_valid(r0_valid),
        .r0_wr_rd(r0_wr_rd),
        .r0_addr (r0_addr),
        .r0_wdata(r0_wdata),
        .r0_ready(r0_ready),
        .r0_rdata(r0_rdata),
        .r1_valid(r1_valid),
        .r1_wr_rd(r1_wr_rd),
        .r1_addr (r1_addr),
        .r1_wdata(r1_wdata),
        .r1_ready(r1_ready),
        .r1_rdata(r1_rdata),
        .m_valid (m_valid),
        .m_wr_rd (m_wr_rd),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .grant   (grant)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .err     (err)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- stimulus state ----------------
    cmd_t    q0[$];
    cmd_t    q1[$];
    int      stall_left = 0;    // scripted m_ready=0 cycles while a request is pending
    bit      rand_ready = 1'b0;
    logic [1:0] dut_glog[$];    // grants as seen on the DUT, in order
    logic [1:0] prev_grant = 2'b00;
    int      mv_cycles = 0;     // DUT cycles with m_valid high

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_model [16];
    logic [DW-1:0] mdl_rdata [2];
    logic [DW-1:0] exp_q[$];    // expected read data, in completion order
    logic          mdl_last;
    bit            t_active;    // a transaction is owned by someone
    bit            t_resp;      // its completion pulse is visible this cycle
    logic          t_owner;
    cmd_t          t_cmd;
    int            t_stalls;
    logic          mdl_err;

    function automatic cmd_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.data = d;
        return c;
    endfunction

    task automatic model_reset();
        mdl_last     = 1'b1;
        t_active     = 1'b0;
        t_resp       = 1'b0;
        t_owner      = 1'b0;
        t_stalls     = 0;
        mdl_err      = 1'b0;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        exp_q.delete();
        prev_grant   = 2'b00;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_req();
        cmd_t c;
        r0_valid = (q0.size() != 0);
        c = r0_valid ? q0[0] : '0;
        {r0_wr_rd, r0_addr, r0_wdata} = c;
        r1_valid = (q1.size() != 0);
        c = r1_valid ? q1[0] : '0;
        {r1_wr_rd, r1_addr, r1_wdata} = c;
    endtask

    task automatic drive_mem();
        if (stall_left > 0 && t_active && !t_resp) begin
            m_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            m_ready = ($urandom_range(0, 3) != 0);
        end else begin
            m_ready = 1'b1;
        end
        m_rdata = mem_model[m_addr];
    endtask

    // One clock: advance the model with the inputs that were applied during
    // the cycle now ending, then compare every output.
    task automatic step();
        logic v0, v1, mr, hs, exp_mv;
        v0 = r0_valid;
        v1 = r1_valid;
        mr = m_ready;
        @(posedge clk);
        #1;
        hs = 1'b0;
        if (t_resp) begin
            t_active = 1'b0;
            t_resp   = 1'b0;
        end else if (t_active) begin
            if (mr) begin
                hs     = 1'b1;
                t_resp = 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else begin
                t_stalls++;
                if (t_stalls == TO) begin
                    t_resp  = 1'b1;
                    mdl_err = 1'b1;
                end
            end
`endif
        end else if (v0 || v1) begin
            t_owner  = (v0 && v1) ? ~mdl_last : v1;
            mdl_last = t_owner;
            t_active = 1'b1;
            t_stalls = 0;
            t_cmd    = t_owner ? q1[0] : q0[0];
        end
        if (hs) begin
            if (t_cmd.wr) begin
                mem_model[t_cmd.addr] = t_cmd.data;
            end else begin
                exp_q.push_back(mem_model[t_cmd.addr]);
                mdl_rdata[t_owner] = mem_model[t_cmd.addr];
            end
        end

        if (grant != 2'b00 && prev_grant == 2'b00) dut_glog.push_back(grant);
        prev_grant = grant;
        if (m_valid) mv_cycles++;

        exp_mv = t_active && !t_resp;
        check("grant", 32'(grant), !t_active ? 32'd0 : (t_owner ? 32'd2 : 32'd1));
        check("m_valid", 32'(m_valid), 32'(exp_mv));
        if (exp_mv) begin
            check("m_wr_rd", 32'(m_wr_rd), 32'(t_cmd.wr));
            check("m_addr", 32'(m_addr), 32'(t_cmd.addr));
            if (t_cmd.wr) check("m_wdata", 32'(m_wdata), 32'(t_cmd.data));
        end
        check("r0_ready", 32'(r0_ready), 32'(t_resp && !t_owner));
        check("r1_ready", 32'(r1_ready), 32'(t_resp && t_owner));
        if (hs && !t_cmd.wr && exp_q.size() != 0)
            check("rdata_sb", 32'(t_owner ? r1_rdata : r0_rdata), 32'(exp_q.pop_front()));
        check("r0_rdata", 32'(r0_rdata), 32'(mdl_rdata[0]));
        check("r1_rdata", 32'(r1_rdata), 32'(mdl_rdata[1]));
`ifdef MEM_ARB_TIMEOUT_EN
        check("err", 32'(err), 32'(mdl_err));
`endif
        // The requester retires its command on seeing its ready pulse.
        if (t_resp) begin
            if (t_owner) void'(q1.pop_front());
            else         void'(q0.pop_front());
        end
        drive_req();
        drive_mem();
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || t_active) && n < max_cycles) begin
            step();
            n++;
        end
        check(tag, 32'(q0.size() == 0 && q1.size() == 0 && !t_active), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem_model[i] = 8'($urandom_range(0, 255));
        model_reset();
        drive_req();
        m_ready = 1'b1;
        m_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_wr_rd", 32'(m_wr_rd), 32'd0);
        check("rst_m_addr", 32'(m_addr), 32'd0);
        check("rst_m_wdata", 32'(m_wdata), 32'd0);
        check("rst_r0_ready", 32'(r0_ready), 32'd0);
        check("rst_r1_ready", 32'(r1_ready), 32'd0);
        check("rst_r0_rdata", 32'(r0_rdata), 32'd0);
        check("rst_r1_rdata", 32'(r1_rdata), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
`ifdef MEM_ARB_TIMEOUT_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        rst = 1'b1;
        drive_mem();

        // r0 writes A5 to address 3 with m_ready tied high.
        q0.push_back(mk(1'b1, 4'd3, 8'hA5));
        drive_req();
        mv_cycles = 0;
        drain("t1_drain", 20);
        check("t1_mvalid_cycles", 32'(mv_cycles), 32'd1);

        // r1 reads it back; r0's read data must stay at its reset value.
        q1.push_back(mk(1'b0, 4'd3, 8'h00));
        drive_req();
        drain("t2_drain", 20);
        check("t2_r1_rdata", 32'(r1_rdata), 32'hA5);
        check("t2_r0_rdata", 32'(r0_rdata), 32'h00);

        // Both continuously valid: strict alternation starting with r0.
        dut_glog.delete();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(1'b1, 4'(i + 4), 8'(8'h10 + i)));
            q1.push_back(mk(1'b0, 4'(i + 4), 8'h00));
        end
        drive_req();
        drain("t3_drain", 40);
        check("t3_grant_count", 32'(dut_glog.size()), 32'd4);
        for (int i = 0; i < 4 && i < dut_glog.size(); i++)
            check("t3_grant_order", 32'(dut_glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

        // Five stall cycles during an r1 write.
        stall_left = 5;
        q1.push_back(mk(1'b1, 4'd9, 8'h3C));
        drive_req();
        mv_cycles = 0;
        drain("t4_drain", 30);
        check("t4_mvalid_cycles", 32'(mv_cycles), 32'd6);
        stall_left = 0;

        // Random traffic with random memory stalls.
        rand_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (q0.size() < 3 && $urandom_range(0, 3) == 0)
                q0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
            if (q1.size() < 3 && $urandom_range(0, 3) == 0)
                q1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
            drive_req();
            step();
        end
        rand_ready = 1'b0;
        drain("rand_drain", 200);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: watchdog releases r0 and sets err.
        stall_left = 1000;
        q0.push_back(mk(1'b0, 4'd2, 8'h00));
        drive_req();
        mv_cycles = 0;
        drain("to_drain", 60);
        check("to_mvalid_cycles", 32'(mv_cycles), 32'd16);
        check("to_err_set", 32'(err), 32'd1);
        stall_left = 0;
        q1.push_back(mk(1'b1, 4'd2, 8'h77));
        drive_req();
        drain("to_next_drain", 20);
        check("to_err_sticky", 32'(err), 32'd1);
`endif

        // Asynchronous reset while a request is in ISSUE.
        stall_left = 3;
        q0.push_back(mk(1'b1, 4'd7, 8'h5A));
        drive_req();
        step();
        check("ar_in_issue", 32'(m_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("ar_m_valid", 32'(m_valid), 32'd0);
        check("ar_grant", 32'(grant), 32'd0);
        check("ar_r0_ready", 32'(r0_ready), 32'd0);
        check("ar_r1_ready", 32'(r1_ready), 32'd0);
        check("ar_m_addr", 32'(m_addr), 32'd0);
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
        stall_left = 0;
        model_reset();
        q0.push_back(mk(1'b0, 4'd9, 8'h00));
        q1.push_back(mk(1'b0, 4'd3, 8'h00));
        drive_req();
        drive_mem();
        rst = 1'b1;
        step();
        check("ar_tie_grant", 32'(grant), 32'd1);
        drain("ar_drain", 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
